// File: rtl/key_pkg.sv
// Shared constants and FSM encoding for the push-button debouncer.
package key_pkg;

    localparam int unsigned CLK_HZ      = 50_000_000;
    localparam int unsigned DEB_CYC_DEF = CLK_HZ / 50;   // 20 ms
    localparam int unsigned REP_DLY_DEF = CLK_HZ;        // 1 s
    localparam int unsigned REP_PER_DEF = CLK_HZ / 5;    // 200 ms

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        PRESS_DB = 2'd1,
        HELD     = 2'd2,
        REL_DB   = 2'd3
    } key_state_e;

    // Counter width able to hold 0..n-1, never narrower than one bit.
    function automatic int unsigned cnt_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/key_debounce_ch.sv
// One key: 2-flop synchronizer, debounce FSM and, with KEY_REPEAT_EN defined,
// hold-to-repeat pulse generation.
module key_debounce_ch
    import key_pkg::*;
#(
    parameter int unsigned DEB_CYC = DEB_CYC_DEF
`ifdef KEY_REPEAT_EN
    ,
    parameter int unsigned REP_DLY = REP_DLY_DEF,
    parameter int unsigned REP_PER = REP_PER_DEF
`endif
) (
    input  logic clk,
    input  logic rst,
    input  logic key_in,
    output logic key_vld,
    output logic key_lvl
);

    localparam int unsigned      CNT_W    = cnt_w(DEB_CYC);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYC - 1);

    logic [1:0]       sync_q;
    logic             synced;
    key_state_e       state;
    key_state_e       state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic             vld_nxt;
    logic             lvl_nxt;
    logic             rep_hit;

    // Synchronizer resets to released so a reset never looks like a press.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= 2'b11;
        end else begin
            sync_q <= {sync_q[0], key_in};
        end
    end

    assign synced = sync_q[1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= '0;
            key_vld <= 1'b0;
            key_lvl <= 1'b0;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            key_vld <= vld_nxt;
            key_lvl <= lvl_nxt;
        end
    end

    // Counter is cleared on every state entry, so it can never wrap.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        vld_nxt   = 1'b0;
        lvl_nxt   = key_lvl;
        case (state)
            IDLE: begin
                if (!synced) begin
                    state_nxt = PRESS_DB;
                    cnt_nxt   = '0;
                end
            end
            PRESS_DB: begin
                if (synced) begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end else if (cnt == CNT_LAST) begin
                    state_nxt = HELD;
                    cnt_nxt   = '0;
                    vld_nxt   = 1'b1;
                    lvl_nxt   = 1'b1;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            HELD: begin
                if (synced) begin
                    state_nxt = REL_DB;
                    cnt_nxt   = '0;
                end
            end
            REL_DB: begin
                if (!synced) begin
                    state_nxt = HELD;
                    cnt_nxt   = '0;
                end else if (cnt == CNT_LAST) begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                    lvl_nxt   = 1'b0;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
        endcase
        if (rep_hit) begin
            vld_nxt = 1'b1;
        end
    end

`ifdef KEY_REPEAT_EN
    localparam int unsigned REP_MAX = (REP_DLY > REP_PER) ? REP_DLY : REP_PER;
    localparam int unsigned REP_W   = cnt_w(REP_MAX);

    logic [REP_W-1:0] rep_cnt;
    logic             rep_first;   // initial REP_DLY wait already elapsed

    assign rep_hit = (state == HELD) &&
                     (rep_cnt == (rep_first ? REP_W'(REP_PER - 1) : REP_W'(REP_DLY - 1)));

    // Runs only in HELD, frozen in REL_DB, cleared once the key is back in IDLE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rep_cnt   <= '0;
            rep_first <= 1'b0;
        end else if (state == IDLE) begin
            rep_cnt   <= '0;
            rep_first <= 1'b0;
        end else if (state == HELD) begin
            if (rep_hit) begin
                rep_cnt   <= '0;
                rep_first <= 1'b1;
            end else begin
                rep_cnt <= rep_cnt + REP_W'(1);
            end
        end
    end
`else
    assign rep_hit = 1'b0;
`endif

endmodule

// File: rtl/key_filter.sv
// Debounces KEY_W active-low push-buttons into press pulses and held levels.
// Optional hold-to-repeat is enabled by defining KEY_REPEAT_EN.
module key_filter
    import key_pkg::*;
#(
    parameter int unsigned KEY_W   = 3,
    parameter int unsigned DEB_CYC = DEB_CYC_DEF
`ifdef KEY_REPEAT_EN
    ,
    parameter int unsigned REP_DLY = REP_DLY_DEF,
    parameter int unsigned REP_PER = REP_PER_DEF
`endif
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [KEY_W-1:0] key_in,
    output logic [KEY_W-1:0] key_vld,
    output logic [KEY_W-1:0] key_lvl
);

    // Keys are fully independent: one channel each, no priority or masking.
    for (genvar i = 0; i < int'(KEY_W); i++) begin : g_ch
        key_debounce_ch #(
            .DEB_CYC (DEB_CYC)
`ifdef KEY_REPEAT_EN
            ,
            .REP_DLY (REP_DLY),
            .REP_PER (REP_PER)
`endif
        ) u_ch (
            .clk     (clk),
            .rst     (rst),
            .key_in  (key_in[i]),
            .key_vld (key_vld[i]),
            .key_lvl (key_lvl[i])
        );
    end

endmodule

// File: tb/tb_key_filter.sv
// Randomized and directed bench for key_filter against a run-length reference model.
module tb_key_filter;

    localparam int KW   = 3;
    localparam int DEB  = 8;
    localparam int RDLY = 40;
    localparam int RPER = 10;

    logic          clk = 1'b0;
    logic          rst;
    logic [KW-1:0] key_in = 3'b111;
    logic [KW-1:0] key_vld;
    logic [KW-1:0] key_lvl;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    key_filter #(
        .KEY_W   (KW),
        .DEB_CYC (DEB)
`ifdef KEY_REPEAT_EN
        ,
        .REP_DLY (RDLY),
        .REP_PER (RPER)
`endif
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .key_in  (key_in),
        .key_vld (key_vld),
        .key_lvl (key_lvl)
    );

    // Reference: a level change is accepted once the key, seen two cycles late,
    // has held its new value for DEB+1 consecutive samples.
    logic [KW-1:0] hist1 = '1;
    logic [KW-1:0] hist2 = '1;
    int            run_len [KW] = '{default: 0};
    bit            run_prs [KW] = '{default: 0};
    bit            m_lvl   [KW] = '{default: 0};
    bit            m_vld   [KW] = '{default: 0};
    bit            prev_prs[KW] = '{default: 0};
    int            hold_cnt[KW] = '{default: 0};
    bit            prs;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            hist1 = '1;
            hist2 = '1;
            for (int k = 0; k < KW; k++) begin
                run_len[k]  = 0;
                run_prs[k]  = 0;
                m_lvl[k]    = 0;
                m_vld[k]    = 0;
                prev_prs[k] = 0;
                hold_cnt[k] = 0;
            end
        end else begin
            for (int k = 0; k < KW; k++) begin
                prs      = ~hist2[k];
                m_vld[k] = 0;
`ifdef KEY_REPEAT_EN
                if (m_lvl[k] && prev_prs[k]) begin
                    hold_cnt[k]++;
                    if (hold_cnt[k] == RDLY ||
                        (hold_cnt[k] > RDLY && (hold_cnt[k] - RDLY) % RPER == 0))
                        m_vld[k] = 1;
                end
`endif
                if (prs == run_prs[k]) begin
                    if (run_len[k] < 1000) run_len[k]++;
                end else begin
                    run_prs[k] = prs;
                    run_len[k] = 1;
                end
                if (run_len[k] == DEB + 1 && prs != m_lvl[k]) begin
                    m_lvl[k] = prs;
                    if (prs) m_vld[k] = 1;
                    else     hold_cnt[k] = 0;
                end
                prev_prs[k] = prs;
            end
            hist2 = hist1;
            hist1 = key_in;
        end
    end

    // Cycle-by-cycle comparison against the model.
    always @(negedge clk) begin
        logic [KW-1:0] e_vld;
        logic [KW-1:0] e_lvl;
        for (int k = 0; k < KW; k++) begin
            e_vld[k] = m_vld[k];
            e_lvl[k] = m_lvl[k];
        end
        n_chk += 2;
        if (key_vld !== e_vld) begin
            n_fail++;
            $display("FAIL model_vld t=%0t got %b expected %b", $time, key_vld, e_vld);
        end
        if (key_lvl !== e_lvl) begin
            n_fail++;
            $display("FAIL model_lvl t=%0t got %b expected %b", $time, key_lvl, e_lvl);
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s t=%0t got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    // Advance n active edges; inputs change and literal checks run 1 ns after the edge.
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    int pulses;
    int pcyc;
    int glitch_p;
    int glitch_drop;
    int rep_cyc[$];
    bit quiet[KW];

    initial begin
        rst = 1'b1;
        tick(3);
        chk("reset_vld", int'(key_vld), 0);
        chk("reset_lvl", int'(key_lvl), 0);
        rst = 1'b0;
        tick(20);

        // Clean press and release on key 0
        key_in[0] = 1'b0;
        tick(10);
        chk("press_before", int'(key_vld), 0);
        tick(1);
        chk("press_pulse", int'(key_vld), 1);
        chk("press_lvl", int'(key_lvl), 1);
        tick(1);
        chk("press_one_wide", int'(key_vld), 0);
        tick(18);
        key_in[0] = 1'b1;
        tick(10);
        chk("release_before", int'(key_lvl), 1);
        tick(1);
        chk("release_lvl", int'(key_lvl), 0);
        chk("release_no_pulse", int'(key_vld), 0);
        tick(10);

        // Bouncing key 1: toggles every 3 cycles, final fall at cycle 18
        pulses = 0;
        pcyc   = -1;
        for (int c = 0; c < 60; c++) begin
            if (c <= 18) key_in[1] = ((c / 3) % 2 == 0) ? 1'b0 : 1'b1;
            tick(1);
            if (key_vld[1]) begin
                pulses++;
                pcyc = c + 1;
            end
        end
        chk("bounce_count", pulses, 1);
        chk("bounce_cycle", pcyc, 29);
        key_in[1] = 1'b1;
        tick(15);

        // Simultaneous press on all keys
        key_in = 3'b000;
        tick(10);
        chk("simul_before", int'(key_vld), 0);
        tick(1);
        chk("simul_pulse", int'(key_vld), 7);
        tick(1);
        chk("simul_after", int'(key_vld), 0);
        key_in = 3'b111;
        tick(15);

        // Reset in the middle of qualifying key 2
        key_in[2] = 1'b0;
        tick(5);
        rst = 1'b1;
        tick(1);
        chk("rst_mid_vld", int'(key_vld), 0);
        chk("rst_mid_lvl", int'(key_lvl), 0);
        rst = 1'b0;
        tick(10);
        chk("rst_requal_before", int'(key_vld), 0);
        tick(1);
        chk("rst_requal_pulse", int'(key_vld), 4);
        chk("rst_requal_lvl", int'(key_lvl), 4);
        key_in[2] = 1'b1;
        tick(15);

        // Short release glitch while key 0 is held
        key_in[0] = 1'b0;
        tick(12);
        key_in[0] = 1'b1;
        tick(4);
        key_in[0] = 1'b0;
        glitch_p    = 0;
        glitch_drop = 0;
        for (int c = 0; c < 20; c++) begin
            tick(1);
            if (key_vld[0])  glitch_p++;
            if (!key_lvl[0]) glitch_drop++;
        end
        chk("glitch_pulses", glitch_p, 0);
        chk("glitch_lvl_drops", glitch_drop, 0);
        key_in[0] = 1'b1;
        tick(15);

        // Long hold on key 0
        key_in[0] = 1'b0;
        for (int c = 0; c < 80; c++) begin
            tick(1);
            if (key_vld[0]) rep_cyc.push_back(c + 1);
        end
`ifdef KEY_REPEAT_EN
        chk("hold_count", rep_cyc.size(), 4);
        if (rep_cyc.size() == 4) begin
            chk("hold_p0", rep_cyc[0], 11);
            chk("hold_p1", rep_cyc[1], 51);
            chk("hold_p2", rep_cyc[2], 61);
            chk("hold_p3", rep_cyc[3], 71);
        end
`else
        chk("hold_count", rep_cyc.size(), 1);
        if (rep_cyc.size() == 1) chk("hold_p0", rep_cyc[0], 11);
`endif
        key_in[0] = 1'b1;
        tick(15);

        // Random traffic: alternating bouncy/quiet stretches, occasional reset
        for (int c = 0; c < 3000; c++) begin
            if (c % 64 == 0)
                for (int k = 0; k < KW; k++) quiet[k] = ($urandom_range(0, 2) != 0);
            for (int k = 0; k < KW; k++)
                if ($urandom_range(0, quiet[k] ? 29 : 2) == 0) key_in[k] = ~key_in[k];
            rst = ($urandom_range(0, 799) == 0);
            tick(1);
        end
        rst    = 1'b0;
        key_in = 3'b111;
        tick(20);
        chk("final_lvl", int'(key_lvl), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
